// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional statistics counters in the top are enabled by FETCH_STATS_EN.
package fetch_pkg;

    localparam int ADDR_WIDTH  = 64;
    localparam int INSTR_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instruction} entries with flush.
// When empty, the head output keeps showing the last entry it presented.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     push_entry_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     entries_q [DEPTH];
    fetch_entry_t     last_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? entries_q[head_q] : last_q;

    // Pointer/count bookkeeping; flush wins over push and pop, and the shown head is snapshotted every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            last_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            last_q <= head_o;
            if (flush_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push_i) begin
                    entries_q[tail_q] <= push_entry_i;
                    tail_q            <= tail_q + PTR_W'(1);
                end
                if (pop_i) begin
                    head_q <= head_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time,
// queues returned instructions and handles redirects.
// Define FETCH_STATS_EN to add the fetched_count/flushed_count outputs.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DEPTH    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_address,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instruction,
`ifdef FETCH_STATS_EN
    output logic [31:0]            fetched_count,
    output logic [31:0]            flushed_count,
`endif
    output logic [ADDR_WIDTH-1:0]  out_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t          state_q;
    logic                  req_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [CNT_W-1:0]      count;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  dropped;

    assign pop        = out_valid && out_ready;
    assign push       = (state_q == WAIT) && imem_ack && !redirect_valid;
    assign dropped    = imem_ack && ((state_q == DISCARD) || ((state_q == WAIT) && redirect_valid));
    assign issue      = (int'(count) + int'(push) - int'(pop)) < DEPTH;
    assign push_entry = '{pc: fetch_pc_q, instruction: imem_data};

    assign imem_req        = req_q;
    assign imem_address    = address_q;
    assign out_valid       = (count != '0);
    assign out_instruction = head.instruction;
    assign out_pc          = head.pc;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .push_entry_i (push_entry),
        .head_o       (head),
        .count_o      (count)
    );

    // Request FSM: holds req/address stable until ack and steers the fetch PC on acks and redirects.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            address_q  <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        state_q    <= WAIT;
                        req_q      <= 1'b1;
                        address_q  <= redirect_pc;
                        fetch_pc_q <= redirect_pc;
                    end else if (issue) begin
                        state_q   <= WAIT;
                        req_q     <= 1'b1;
                        address_q <= fetch_pc_q;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                        if (imem_ack) begin
                            address_q <= redirect_pc;
                        end else begin
                            state_q <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        fetch_pc_q <= fetch_pc_q + PC_STEP;
                        if (issue) begin
                            address_q <= fetch_pc_q + PC_STEP;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                    end
                    if (imem_ack) begin
                        state_q   <= WAIT;
                        address_q <= redirect_valid ? redirect_pc : fetch_pc_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q;
    logic [31:0] flushed_q;

    assign fetched_count = fetched_q;
    assign flushed_count = flushed_q;

    // Accepted instructions count on every pop; discards are flushed entries left after a pop plus dropped responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(pop);
            flushed_q <= flushed_q
                       + (redirect_valid ? (32'(count) - 32'(pop)) : 32'd0)
                       + 32'(dropped);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (DEPTH=4, RESET_PC=0).
// Statistic outputs are checked only when FETCH_STATS_EN is defined.
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_address;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [63:0] out_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] fetched_count;
    logic [31:0] flushed_count;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    instruction_fetch_unit #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .clock           (clock),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_address    (imem_address),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
`ifdef FETCH_STATS_EN
        .fetched_count   (fetched_count),
        .flushed_count   (flushed_count),
`endif
        .out_pc          (out_pc)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Instruction word the memory returns for a given PC.
    function automatic logic [31:0] instrFor(input logic [63:0] pc);
        return 32'h1000_0000 + pc[31:0];
    endfunction

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive inputs just after an edge, then advance one clock and settle.
    task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic ack,
                                 input logic [31:0] data, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = ack;
        imem_data      = data;
        out_ready      = rdy;
        @(posedge clock);
        #1;
    endtask

    // Pulse reset for one edge, release it and take the first post-reset edge.
    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b0;
        imem_data      = '0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        checkOutput("rst_req", imem_req, 0);
        checkOutput("rst_addr", imem_address, 64'h0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_instr", out_instruction, 0);
        checkOutput("rst_pc", out_pc, 0);
`ifdef FETCH_STATS_EN
        checkOutput("rst_fetched", fetched_count, 0);
        checkOutput("rst_flushed", flushed_count, 0);
`endif

        // First edge with reset released issues at RESET_PC
        reset = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("start_req", imem_req, 1);
        checkOutput("start_addr", imem_address, 64'h0);

        // Zero-wait memory with ready high: one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, instrFor(64'(4 * i)), 1'b1);
            checkOutput($sformatf("zw_valid%0d", i), out_valid, 1);
            checkOutput($sformatf("zw_pc%0d", i), out_pc, 64'(4 * i));
            checkOutput($sformatf("zw_instr%0d", i), out_instruction, instrFor(64'(4 * i)));
            checkOutput($sformatf("zw_addr%0d", i), imem_address, 64'(4 * i + 4));
        end

        // Back-pressure: exactly DEPTH acks accepted, then request stops
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, instrFor(64'(4 * i)), 1'b0);
        end
        checkOutput("full_req", imem_req, 0);
        checkOutput("full_valid", out_valid, 1);
        checkOutput("full_pc", out_pc, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("full_req_hold", imem_req, 0);
        checkOutput("full_pc_hold", out_pc, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("resume_req", imem_req, 1);
        checkOutput("resume_addr", imem_address, 64'h10);
        checkOutput("resume_pc", out_pc, 64'h4);
        applyStimulus(1'b0, 64'h0, 1'b1, instrFor(64'h10), 1'b1);
        checkOutput("resume_pc2", out_pc, 64'h8);
        checkOutput("resume_addr2", imem_address, 64'h14);

        // Ack delayed three cycles: address held, data visible one cycle after ack
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("slow_req%0d", i), imem_req, 1);
            checkOutput($sformatf("slow_addr%0d", i), imem_address, 64'h0);
            checkOutput($sformatf("slow_valid%0d", i), out_valid, 0);
        end
        applyStimulus(1'b0, 64'h0, 1'b1, 32'hF840_03E1, 1'b0);
        checkOutput("slow_valid", out_valid, 1);
        checkOutput("slow_instr", out_instruction, 32'hF840_03E1);
        checkOutput("slow_pc", out_pc, 64'h0);

        // Redirect with request at 0x8 outstanding: DISCARD then restart at 0x100
        applyStimulus(1'b0, 64'h0, 1'b1, instrFor(64'h4), 1'b0);
        checkOutput("pre_redir_addr", imem_address, 64'h8);
        applyStimulus(1'b1, 64'h100, 1'b0, 32'h0, 1'b0);
        checkOutput("disc_valid", out_valid, 0);
        checkOutput("disc_req", imem_req, 1);
        checkOutput("disc_addr", imem_address, 64'h8);
        checkOutput("disc_hold_pc", out_pc, 64'h0);
        checkOutput("disc_hold_instr", out_instruction, 32'hF840_03E1);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("disc_addr2", imem_address, 64'h8);
        applyStimulus(1'b0, 64'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("disc_drop_valid", out_valid, 0);
        checkOutput("disc_next_addr", imem_address, 64'h100);
        applyStimulus(1'b0, 64'h0, 1'b1, instrFor(64'h100), 1'b1);
        checkOutput("redir_valid", out_valid, 1);
        checkOutput("redir_pc", out_pc, 64'h100);
        checkOutput("redir_instr", out_instruction, instrFor(64'h100));
`ifdef FETCH_STATS_EN
        checkOutput("stats_fetched_a", fetched_count, 0);
        checkOutput("stats_flushed_a", flushed_count, 3);
`endif

        // Redirect coincident with ack and pop
        applyStimulus(1'b1, 64'h200, 1'b1, instrFor(64'h104), 1'b1);
        checkOutput("coin_valid", out_valid, 0);
        checkOutput("coin_req", imem_req, 1);
        checkOutput("coin_addr", imem_address, 64'h200);
`ifdef FETCH_STATS_EN
        checkOutput("stats_fetched_b", fetched_count, 1);
        checkOutput("stats_flushed_b", flushed_count, 4);
`endif

        // Fill three entries, leave a request outstanding, then reset
        applyStimulus(1'b0, 64'h0, 1'b1, instrFor(64'h200), 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, instrFor(64'h204), 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, instrFor(64'h208), 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("pre_rst_req", imem_req, 1);
        checkOutput("pre_rst_addr", imem_address, 64'h20C);
        checkOutput("pre_rst_pc", out_pc, 64'h200);
        reset = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_req", imem_req, 0);
        checkOutput("mid_rst_addr", imem_address, 64'h0);
        checkOutput("mid_rst_pc", out_pc, 64'h0);
`ifdef FETCH_STATS_EN
        checkOutput("mid_rst_fetched", fetched_count, 0);
`endif
        reset = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("restart_req", imem_req, 1);
        checkOutput("restart_addr", imem_address, 64'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
